// File: rtl/execute_pipe.sv
// execute_pipe: single-issue execute stage with registered output and a serial radix-2 multiplier.
module execute_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] read_data1,
  input  logic [XLEN-1:0] read_data2,
  input  logic [XLEN-1:0] imm,
  input  logic            ALUSrc,
  input  logic            Branch,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ALU_result,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_target,
  output logic            illegal
);
  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;
  typedef enum logic {IDLE, MUL} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d, acc_q, acc_d, prod;
  logic [XLEN-1:0] mplier_q, mplier_d, tgt_q, tgt_d;
  logic neg_q, neg_d, hi_q, hi_d;
  logic out_valid_q, out_valid_d, taken_q, taken_d, illegal_q, illegal_d;
  logic [XLEN-1:0] result_q, result_d, target_q, target_d;
  logic [XLEN-1:0] op2, sra, alu_res, mag_a, mag_b, mul_res;
  logic [SW-1:0] sh;
  logic is_m, mul_go, accept, eq, lt, ltu, br_tk, br_ill, a_neg, b_neg;
  assign in_ready = (state_q == IDLE) & (!out_valid_q | out_ready) & !flush & !reset;
  assign accept = in_valid & in_ready;
  assign op2 = ALUSrc ? imm : read_data2;
  assign sh = op2[SW-1:0];
  assign sra = $signed(read_data1) >>> sh;
  assign is_m = (funct7 == 7'b0000001) & !Branch;
  assign mul_go = is_m & !ALUSrc & !funct3[2];
  assign eq = read_data1 == read_data2;
  assign lt = $signed(read_data1) < $signed(read_data2);
  assign ltu = read_data1 < read_data2;
  assign br_ill = funct3[2:1] == 2'b01;
  // MULH and MULHSU treat rs1 as signed; only MULH treats rs2 as signed
  assign a_neg = (funct3[1] ^ funct3[0]) & read_data1[XLEN-1];
  assign b_neg = (funct3[1:0] == 2'b01) & read_data2[XLEN-1];
  assign mag_a = a_neg ? -read_data1 : read_data1;
  assign mag_b = b_neg ? -read_data2 : read_data2;
  assign prod = neg_q ? -acc_q : acc_q;
  assign mul_res = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  assign out_valid = out_valid_q;
  assign ALU_result = result_q;
  assign branch_taken = taken_q;
  assign branch_target = target_q;
  assign illegal = illegal_q;
  always_comb begin
    alu_res = '0;
    case (funct3)
      3'b000: alu_res = (!ALUSrc && funct7[5]) ? read_data1 - op2 : read_data1 + op2;
      3'b001: alu_res = read_data1 << sh;
      3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(read_data1) < $signed(op2)};
      3'b011: alu_res = {{(XLEN-1){1'b0}}, read_data1 < op2};
      3'b100: alu_res = read_data1 ^ op2;
      3'b101: alu_res = funct7[5] ? sra : read_data1 >> sh;
      3'b110: alu_res = read_data1 | op2;
      3'b111: alu_res = read_data1 & op2;
      default: alu_res = '0;
    endcase
  end
  always_comb begin
    br_tk = 1'b0;
    case (funct3)
      3'b000: br_tk = eq;
      3'b001: br_tk = !eq;
      3'b100: br_tk = lt;
      3'b101: br_tk = !lt;
      3'b110: br_tk = ltu;
      3'b111: br_tk = !ltu;
      default: br_tk = 1'b0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    acc_d = acc_q;
    neg_d = neg_q;
    hi_d = hi_q;
    tgt_d = tgt_q;
    out_valid_d = out_valid_q;
    result_d = result_q;
    taken_d = taken_q;
    target_d = target_q;
    illegal_d = illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
      state_d = IDLE;
      cnt_d = '0;
    end else begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      if (state_q == MUL) begin
        if (cnt_q != CW'(XLEN)) begin
          acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
          mcand_d = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d = cnt_q + 1'b1;
        end else if (!out_valid_q || out_ready) begin
          out_valid_d = 1'b1;
          result_d = mul_res;
          taken_d = 1'b0;
          target_d = tgt_q;
          illegal_d = 1'b0;
          state_d = IDLE;
          cnt_d = '0;
        end
      end
      if (accept && mul_go) begin
        state_d = MUL;
        cnt_d = '0;
        acc_d = '0;
        mcand_d = {{XLEN{1'b0}}, mag_a};
        mplier_d = mag_b;
        neg_d = a_neg ^ b_neg;
        hi_d = funct3[1:0] != 2'b00;
        tgt_d = pc + imm;
      end else if (accept) begin
        out_valid_d = 1'b1;
        result_d = (Branch || is_m) ? '0 : alu_res;
        taken_d = Branch & br_tk & !br_ill;
        target_d = pc + imm;
        illegal_d = Branch ? br_ill : is_m;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      acc_q <= '0;
      neg_q <= 1'b0;
      hi_q <= 1'b0;
      tgt_q <= '0;
      out_valid_q <= 1'b0;
      result_q <= '0;
      taken_q <= 1'b0;
      target_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      acc_q <= acc_d;
      neg_q <= neg_d;
      hi_q <= hi_d;
      tgt_q <= tgt_d;
      out_valid_q <= out_valid_d;
      result_q <= result_d;
      taken_q <= taken_d;
      target_q <= target_d;
      illegal_q <= illegal_d;
    end
  end
endmodule

// File: tb/tb_execute_pipe.sv
// tb_execute_pipe: random and directed stimulus against an arithmetic reference model of execute_pipe.
module tb_execute_pipe;
  logic clk = 0, reset = 1, flush = 0, in_valid = 0, ALUSrc = 0, Branch = 0, out_ready = 1;
  logic in_ready, out_valid, branch_taken, illegal;
  logic [31:0] pc = 0, read_data1 = 0, read_data2 = 0, imm = 0, ALU_result, branch_target;
  logic [2:0] funct3 = 0;
  logic [6:0] funct7 = 0;
  int errors = 0, checks = 0;
  bit run = 0;
  execute_pipe #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .read_data1(read_data1), .read_data2(read_data2), .imm(imm),
    .ALUSrc(ALUSrc), .Branch(Branch), .funct3(funct3), .funct7(funct7),
    .out_valid(out_valid), .out_ready(out_ready), .ALU_result(ALU_result),
    .branch_taken(branch_taken), .branch_target(branch_target), .illegal(illegal)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  typedef struct packed {logic [31:0] res; logic tk; logic ill; logic mul;} op_t;
  function automatic op_t model_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                                   input logic src, input logic br, input logic [2:0] f3, input logic [6:0] f7);
    op_t o;
    logic [31:0] o2;
    logic [63:0] p;
    o = '0;
    o2 = src ? im : b;
    if (br) begin
      o.ill = (f3 == 3'd2) || (f3 == 3'd3);
      case (f3)
        3'd0: o.tk = a == b;
        3'd1: o.tk = a != b;
        3'd4: o.tk = $signed(a) < $signed(b);
        3'd5: o.tk = $signed(a) >= $signed(b);
        3'd6: o.tk = a < b;
        3'd7: o.tk = a >= b;
        default: o.tk = 0;
      endcase
    end else if (f7 == 7'd1) begin
      if (src || f3[2]) o.ill = 1;
      else begin
        o.mul = 1;
        case (f3[1:0])
          2'd0: p = {32'b0, a} * {32'b0, b};
          2'd1: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
          2'd2: p = {{32{a[31]}}, a} * {32'b0, b};
          default: p = {32'b0, a} * {32'b0, b};
        endcase
        o.res = (f3[1:0] == 2'd0) ? p[31:0] : p[63:32];
      end
    end else begin
      case (f3)
        3'd0: o.res = (!src && f7[5]) ? a - o2 : a + o2;
        3'd1: o.res = a << o2[4:0];
        3'd2: o.res = {31'b0, $signed(a) < $signed(o2)};
        3'd3: o.res = {31'b0, a < o2};
        3'd4: o.res = a ^ o2;
        3'd5: if (f7[5]) o.res = $signed(a) >>> o2[4:0]; else o.res = a >> o2[4:0];
        3'd6: o.res = a | o2;
        default: o.res = a & o2;
      endcase
    end
    return o;
  endfunction
  bit m_valid = 0, m_tk = 0, m_ill = 0;
  logic [31:0] m_res = 0, m_tgt = 0, p_res = 0, p_tgt = 0;
  int m_left = 0;
  function automatic bit m_rdy();
    return !reset && m_left == 0 && (!m_valid || out_ready) && !flush;
  endfunction
  always @(posedge clk) begin : model
    op_t o;
    bit acc;
    acc = in_valid && m_rdy();
    if (reset) begin
      m_valid = 0; m_res = 0; m_tgt = 0; m_tk = 0; m_ill = 0; m_left = 0;
    end else if (flush) begin
      m_valid = 0; m_left = 0;
    end else begin
      if (m_valid && out_ready) m_valid = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_valid = 1; m_res = p_res; m_tgt = p_tgt; m_tk = 0; m_ill = 0;
        end
      end
      if (acc) begin
        o = model_op(read_data1, read_data2, imm, ALUSrc, Branch, funct3, funct7);
        if (o.mul) begin
          m_left = 33; p_res = o.res; p_tgt = pc + imm;
        end else begin
          m_valid = 1; m_res = o.res; m_tk = o.tk; m_ill = o.ill; m_tgt = pc + imm;
        end
      end
    end
  end
  always @(negedge clk) if (run) begin
    check("out_valid", out_valid, m_valid);
    check("in_ready", in_ready, m_rdy());
    if (m_valid) begin
      check("ALU_result", ALU_result, m_res);
      check("branch_taken", branch_taken, m_tk);
      check("branch_target", branch_target, m_tgt);
      check("illegal", illegal, m_ill);
    end
  end
  task automatic send(input logic [31:0] p, input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                      input logic src, input logic br, input logic [2:0] f3, input logic [6:0] f7);
    pc = p; read_data1 = a; read_data2 = b; imm = im; ALUSrc = src; Branch = br; funct3 = f3; funct7 = f7;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic mul_lat(input string name, input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                         input logic [31:0] exp);
    bit bad = 0;
    send(0, a, b, 0, 0, 0, f3, 7'h01);
    repeat (33) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b0) bad = 1;
    end
    check({name, "_busy"}, bad, 0);
    @(negedge clk);
    check({name, "_valid"}, out_valid, 1);
    check({name, "_res"}, ALU_result, exp);
  endtask
  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bit bad;
    @(posedge clk);
    #1 run = 1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_outputs", {out_valid, branch_taken, illegal, |ALU_result, |branch_target}, 0);
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("in_ready_after_reset", in_ready, 1);
    send(0, 3, 5, 0, 0, 0, 3'd0, 7'h20);
    @(negedge clk);
    check("sub_valid", out_valid, 1);
    check("sub_res", ALU_result, 32'hFFFFFFFE);
    send(0, 32'h80000000, 0, 32'h404, 1, 0, 3'd5, 7'h20);
    @(negedge clk);
    check("srai_res", ALU_result, 32'hF8000000);
    send(0, 32'h80000000, 0, 32'h404, 1, 0, 3'd5, 7'h00);
    @(negedge clk);
    check("srli_res", ALU_result, 32'h08000000);
    send(32'h100, 32'hFFFFFFFF, 1, 32'hFFFFFFF0, 0, 1, 3'd4, 0);
    @(negedge clk);
    check("blt_taken", branch_taken, 1);
    check("blt_target", branch_target, 32'hF0);
    send(32'h100, 32'hFFFFFFFF, 1, 32'hFFFFFFF0, 0, 1, 3'd6, 0);
    @(negedge clk);
    check("bltu_taken", branch_taken, 0);
    send(32'h100, 32'hFFFFFFFF, 1, 32'hFFFFFFF0, 0, 1, 3'd2, 0);
    @(negedge clk);
    check("br010_illegal", illegal, 1);
    check("br010_res", ALU_result, 0);
    send(0, 7, 0, 0, 0, 0, 3'd4, 7'h01);
    @(negedge clk);
    check("div_illegal", illegal, 1);
    mul_lat("mulh", 32'hFFFFFFFE, 3, 3'd1, 32'hFFFFFFFF);
    mul_lat("mul", 32'hFFFFFFFE, 3, 3'd0, 32'hFFFFFFFA);
    mul_lat("mulhu", 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd3, 32'hFFFFFFFE);
    mul_lat("mulhsu", 32'hFFFFFFFF, 2, 3'd2, 32'hFFFFFFFF);
    @(posedge clk);
    #1 out_ready = 0;
    send(0, 10, 20, 0, 0, 0, 3'd0, 0);
    read_data1 = 7; read_data2 = 8; in_valid = 1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || ALU_result !== 32'd30 || in_ready !== 1'b0) bad = 1;
    end
    check("stall_hold", bad, 0);
    out_ready = 1;
    @(posedge clk);
    #1 in_valid = 0;
    @(negedge clk);
    check("stall_next_valid", out_valid, 1);
    check("stall_next_res", ALU_result, 15);
    send(0, 5, 7, 0, 0, 0, 3'd0, 7'h01);
    repeat (9) @(posedge clk);
    #1 flush = 1;
    @(posedge clk);
    #1 flush = 0;
    @(negedge clk);
    check("flush_in_ready", in_ready, 1);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad = 1;
    end
    check("flush_no_result", bad, 0);
    send(32'h40, 1, 2, 4, 0, 0, 3'd0, 0);
    send(0, 5, 7, 0, 0, 0, 3'd0, 7'h01);
    repeat (9) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("reset_outputs", {out_valid, branch_taken, illegal, |ALU_result, |branch_target}, 0);
    check("reset_in_ready", in_ready, 1);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad = 1;
    end
    check("reset_no_result", bad, 0);
    repeat (4000) begin
      @(posedge clk);
      #1;
      reset = $urandom_range(0, 199) == 0;
      flush = $urandom_range(0, 49) == 0;
      in_valid = $urandom_range(0, 9) < 6;
      out_ready = $urandom_range(0, 3) != 0;
      pc = $urandom;
      read_data1 = rnd();
      read_data2 = ($urandom_range(0, 5) == 0) ? read_data1 : rnd();
      imm = rnd();
      ALUSrc = 1'($urandom_range(0, 1));
      Branch = $urandom_range(0, 3) == 0;
      funct3 = 3'($urandom);
      case ($urandom_range(0, 3))
        0: funct7 = 7'h00;
        1: funct7 = 7'h20;
        2: funct7 = 7'h01;
        default: funct7 = 7'($urandom);
      endcase
    end
    @(posedge clk);
    #1 reset = 0; flush = 0; in_valid = 0; out_ready = 1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/execute_pipe.md
EXECUTE_PIPE -- requirements
Module: execute_pipe

Interface
REQ-001 Parameter XLEN, 32, datapath width; SHALL support 32 and 64.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  sole clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  kill in-flight op and output.
- in_valid  in  1  op present.
- in_ready  out  1  op accepted when in_valid&in_ready.
- pc  in  XLEN  instruction address.
- read_data1  in  XLEN  rs1 value.
- read_data2  in  XLEN  rs2 value.
- imm  in  XLEN  sign-extended immediate.
- ALUSrc  in  1  1: operand2=imm, 0: operand2=read_data2.
- Branch  in  1  conditional-branch op.
- funct3  in  3  op select.
- funct7  in  7  op modifier.
- out_valid  out  1  result register valid.
- out_ready  in  1  consumer accepts when out_valid&out_ready.
- ALU_result  out  XLEN  registered result.
- branch_taken  out  1  registered branch decision.
- branch_target  out  XLEN  registered pc+imm.
- illegal  out  1  registered unsupported-op flag.
REQ-003 One clock; reset is synchronous and active-high.

Function
REQ-004 FSM states IDLE, MUL; single output register; no other storage for ops.
REQ-005 in_ready SHALL = (state==IDLE) & (!out_valid | out_ready) & !flush.
REQ-006 Single-cycle ops: accepted at edge N -> out_valid=1 and outputs loaded at edge N; visible cycle N+1.
REQ-007 ALU (Branch=0, funct7!=0000001): 000 ADD, or SUB when !ALUSrc & funct7[5]; 001 SLL; 010 SLT signed; 011 SLTU; 100 XOR; 101 SRL, SRA when funct7[5] (both ALUSrc values); 110 OR; 111 AND.
REQ-008 Shift amount SHALL be operand2[$clog2(XLEN)-1:0]; all arithmetic modulo 2^XLEN; SLT/SLTU result 0 or 1 zero-extended.
REQ-009 Branch=1: branch_taken per funct3 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU on read_data1/read_data2; funct3 010/011 -> taken=0, illegal=1; ALU_result=0.
REQ-010 branch_target SHALL = pc+imm mod 2^XLEN for every op; branch_taken=0 when Branch=0.
REQ-011 MUL ops (funct7=0000001, Branch=0, ALUSrc=0): 000 MUL low XLEN, 001 MULH s*s high, 010 MULHSU s*u high, 011 MULHU u*u high.
REQ-012 MUL: accept -> state MUL; radix-2 shift-add on operand magnitudes, one step per cycle, XLEN steps; product negated if signs differ; out_valid rises at edge XLEN+1 after acceptance edge; state -> IDLE same edge.
REQ-013 funct7=0000001 with funct3 1xx (divide), or with ALUSrc=1: single-cycle, ALU_result=0, illegal=1.
REQ-014 While out_valid & !out_ready, all outputs SHALL hold stable; MUL completion waits only if output still occupied (in_ready rule prevents this).
REQ-015 out_valid & out_ready with no new accept -> out_valid=0 next edge; with simultaneous accept -> new result loaded, out_valid stays 1.
REQ-016 flush=1 at an edge: out_valid=0, state -> IDLE, MUL discarded, no accept; flush dominates in_valid/out_ready.

Reset
REQ-017 reset=1 at edge: state IDLE, counter 0, out_valid=0, ALU_result=0, branch_taken=0, branch_target=0, illegal=0; overrides flush and in-flight MUL.
REQ-018 in_ready SHALL be 0 while reset=1 and 1 in first cycle after release.

Verification (XLEN=32)
REQ-019 SUB: rs1=3, rs2=5, funct3=000, funct7=0x20, ALUSrc=0 -> ALU_result=0xFFFFFFFE, out_valid one cycle after accept.
REQ-020 SRAI: rs1=0x80000000, imm=0x404, funct3=101, funct7=0x20, ALUSrc=1 -> 0xF8000000; same with funct7=0 -> 0x08000000.
REQ-021 Branch pc=0x100, imm=0xFFFFFFF0, rs1=0xFFFFFFFF, rs2=1: funct3=100 -> taken=1, target=0xF0; funct3=110 -> taken=0; funct3=010 -> illegal=1.
REQ-022 MULH rs1=0xFFFFFFFE, rs2=3 -> 0xFFFFFFFF; MUL -> 0xFFFFFFFA; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; out_valid 33 cycles after accept, in_ready=0 throughout.
REQ-023 out_ready=0 for 3 cycles after ADD result: outputs stable, in_ready=0; out_ready=1 with queued in_valid -> new result loaded, out_valid continuous.
REQ-024 flush at cycle 10 of MUL -> no out_valid, in_ready=1 next cycle; repeat with reset -> all outputs 0.
